// File: rtl/button_reader.sv
// Push-button front end: synchronises and debounces one raw pin on clk24, then
// classifies it into a clean level, press/release/long-press pulses and a press count.
module button_reader #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int LONG_CYCLES     = 24000000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int CNT_W           = 8
) (
  input  logic             clk24,
  input  logic             rst,
  input  logic             btn_in,
  output logic             btn_level,
  output logic             press_p,
  output logic             release_p,
  output logic             long_p,
  output logic [CNT_W-1:0] press_cnt
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRESS_WAIT = 3'd1,
    ST_HELD       = 3'd2,
    ST_LONG_HELD  = 3'd3,
    ST_REL_WAIT   = 3'd4
  } state_t;

  state_t        state_r;
  logic          sync1_r;
  logic          sync2_r;
  logic [DW-1:0] dcnt_r;
  logic [HW-1:0] hcnt_r;
  logic          long_flag_r;
  logic          pressed_s;

  // Normalise polarity so pressed_s = 1 always means the button is down.
  assign pressed_s = sync2_r ^ ACTIVE_LOW;

  // Two-flop synchroniser; resets to the idle pin level so reset never looks like a press.
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      sync1_r <= ACTIVE_LOW;
      sync2_r <= ACTIVE_LOW;
    end else begin
      sync1_r <= btn_in;
      sync2_r <= sync1_r;
    end
  end

  // Debounce/classification FSM with registered level, pulses and press count.
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      dcnt_r      <= '0;
      hcnt_r      <= '0;
      long_flag_r <= 1'b0;
      btn_level   <= 1'b0;
      press_p     <= 1'b0;
      release_p   <= 1'b0;
      long_p      <= 1'b0;
      press_cnt   <= '0;
    end else begin
      press_p   <= 1'b0;
      release_p <= 1'b0;
      long_p    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pressed_s) begin
            state_r <= ST_PRESS_WAIT;
            dcnt_r  <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!pressed_s) begin
            state_r <= ST_IDLE;
          end else if (dcnt_r == D_LAST) begin
            state_r   <= ST_HELD;
            press_p   <= 1'b1;
            btn_level <= 1'b1;
            hcnt_r    <= '0;
            press_cnt <= press_cnt + CNT_W'(1);
          end else begin
            dcnt_r <= dcnt_r + DW'(1);
          end
        end
        // A release in the same cycle the hold expires takes priority over long_p.
        ST_HELD: begin
          if (!pressed_s) begin
            state_r <= ST_REL_WAIT;
            dcnt_r  <= '0;
          end else if (hcnt_r == H_LAST) begin
            state_r     <= ST_LONG_HELD;
            long_p      <= 1'b1;
            long_flag_r <= 1'b1;
          end else begin
            hcnt_r <= hcnt_r + HW'(1);
          end
        end
        ST_LONG_HELD: begin
          if (!pressed_s) begin
            state_r <= ST_REL_WAIT;
            dcnt_r  <= '0;
          end
        end
        // A bounce back to pressed resumes the hold without a new press or count.
        ST_REL_WAIT: begin
          if (pressed_s) begin
            state_r <= long_flag_r ? ST_LONG_HELD : ST_HELD;
          end else if (dcnt_r == D_LAST) begin
            state_r     <= ST_IDLE;
            release_p   <= 1'b1;
            btn_level   <= 1'b0;
            long_flag_r <= 1'b0;
          end else begin
            dcnt_r <= dcnt_r + DW'(1);
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          btn_level   <= 1'b0;
          long_flag_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_reader.sv
// Scoreboard bench for button_reader: stimulus pushes expected pulse events,
// a negedge monitor pops and compares them whenever the DUT emits a pulse.
module tb_button_reader;

  localparam int K_PRESS = 1;
  localparam int K_REL   = 2;
  localparam int K_LONG  = 3;

  typedef struct {
    int kind;
    int edge_n;
    int cnt;
    int level;
  } ev_t;

  logic       clk24 = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b1;
  logic       btn_level;
  logic       press_p;
  logic       release_p;
  logic       long_p;
  logic [1:0] press_cnt;

  int  edge_cnt = 0;
  int  checks = 0;
  int  failures = 0;
  ev_t sb[$];

  button_reader #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(20),
    .ACTIVE_LOW(1'b1),
    .CNT_W(2)
  ) dut (
    .clk24(clk24),
    .rst(rst),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .press_p(press_p),
    .release_p(release_p),
    .long_p(long_p),
    .press_cnt(press_cnt)
  );

  always #5 clk24 = ~clk24;

  always @(posedge clk24) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk24);
  endtask

  task automatic expect_ev(input int kind, input int e, input int cnt, input int lvl);
    ev_t ev;
    ev.kind = kind;
    ev.edge_n = e;
    ev.cnt = cnt;
    ev.level = lvl;
    sb.push_back(ev);
  endtask

  task automatic chk_quiet(input string name, input int cnt);
    chk({name, "_level"}, int'(btn_level), 0);
    chk({name, "_pulses"}, int'({press_p, release_p, long_p}), 0);
    chk({name, "_cnt"}, int'(press_cnt), cnt);
  endtask

  // One press/release cycle with the expected pulse edges pushed up front.
  task automatic press_release(input int hold, input int cnt);
    int t0;
    int tr;
    t0 = edge_cnt;
    btn_in = 1'b0;
    expect_ev(K_PRESS, t0 + 7, cnt, 1);
    cycles(hold);
    tr = edge_cnt;
    btn_in = 1'b1;
    expect_ev(K_REL, tr + 7, cnt, 0);
    cycles(12);
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk24) begin
    ev_t exp_ev;
    int  kind;
    if (press_p || release_p || long_p) begin
      chk("pulse_onehot", $countones({press_p, release_p, long_p}), 1);
      kind = press_p ? K_PRESS : (release_p ? K_REL : K_LONG);
      if (sb.size() == 0) begin
        chk("unexpected_pulse_kind", kind, 0);
      end else begin
        exp_ev = sb.pop_front();
        chk("ev_kind", kind, exp_ev.kind);
        chk("ev_edge", edge_cnt, exp_ev.edge_n);
        chk("ev_cnt", int'(press_cnt), exp_ev.cnt);
        chk("ev_level", int'(btn_level), exp_ev.level);
      end
    end
  end

  initial begin
    int t0;
    int tr;

    // 1: reset with the pin idle-high
    cycles(3);
    chk_quiet("in_reset", 0);
    rst = 1'b0;
    cycles(50);
    chk_quiet("idle50", 0);

    // 2: clean press held 40 cycles, long press, then release
    t0 = edge_cnt;
    btn_in = 1'b0;
    expect_ev(K_PRESS, t0 + 7, 1, 1);
    expect_ev(K_LONG, t0 + 27, 1, 1);
    cycles(10);
    chk("held_level", int'(btn_level), 1);
    chk("held_cnt", int'(press_cnt), 1);
    cycles(30);
    tr = edge_cnt;
    btn_in = 1'b1;
    expect_ev(K_REL, tr + 7, 1, 0);
    cycles(15);
    chk_quiet("after_long", 1);

    // 3: short low bounces are rejected
    for (int w = 1; w <= 3; w++) begin
      btn_in = 1'b0;
      cycles(w);
      btn_in = 1'b1;
      cycles(8);
    end
    chk_quiet("bounces", 1);

    // 4: 2-cycle release glitch while held, then clean release
    t0 = edge_cnt;
    btn_in = 1'b0;
    expect_ev(K_PRESS, t0 + 7, 2, 1);
    cycles(15);
    btn_in = 1'b1;
    cycles(2);
    btn_in = 1'b0;
    cycles(5);
    chk("glitch_level", int'(btn_level), 1);
    chk("glitch_cnt", int'(press_cnt), 2);
    tr = edge_cnt;
    btn_in = 1'b1;
    expect_ev(K_REL, tr + 7, 2, 0);
    cycles(12);

    // 5a: release seen exactly when hcnt==19 -> no long_p
    press_release(24, 3);
    chk_quiet("boundary_release", 3);

    // 6: reset during PRESS_WAIT
    btn_in = 1'b0;
    cycles(4);
    rst = 1'b1;
    #1;
    chk_quiet("rst_press_wait", 0);
    cycles(1);
    btn_in = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(6);
    chk_quiet("post_rst1", 0);

    // 6: reset during HELD (press_cnt wrapped 3->0 by reset, this press makes 1)
    t0 = edge_cnt;
    btn_in = 1'b0;
    expect_ev(K_PRESS, t0 + 7, 1, 1);
    cycles(12);
    rst = 1'b1;
    #1;
    chk_quiet("rst_held", 0);
    cycles(1);
    btn_in = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(6);
    chk_quiet("post_rst2", 0);

    // 5b/6: five full presses after reset -> counts 1,2,3,0,1
    for (int k = 1; k <= 5; k++) begin
      press_release(10, k % 4);
    end
    chk_quiet("after_wrap", 1);

    chk("pending_events", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
